// File: rtl/calc_pkg.sv
// Shared calculator package: bcd_digit_writer FSM states and display constants.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT,
        DONE
    } bdw_state_t;

    localparam int          NDIG     = 8;
    localparam logic [3:0]  POS_IDLE = 4'hF;
    localparam logic [3:0]  DIG_IDLE = 4'hF;
    localparam logic [26:0] MAX_DISP = 27'd99_999_999;

endpackage

// File: rtl/bcd_digit_writer_if.sv
// Display write port bundle between the digit writer and its requester/display.
interface bcd_digit_writer_if #(
    parameter int W = 27
);
    logic         start;
    logic [W-1:0] value;
    logic [3:0]   dig;
    logic [3:0]   pos;
    logic         busy;
    logic         done;
    logic         ovf;

    modport master (
        output start, value,
        input  dig, pos, busy, done, ovf
    );

    modport slave (
        input  start, value,
        output dig, pos, busy, done, ovf
    );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble cell: add 3 to a BCD digit when it is 5 or more.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Pre-shift correction so the following left shift carries into the next digit.
    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bcd_digit_writer.sv
// Binary-to-BCD converter (sequential double dabble) that streams eight
// digits as (dig, pos) writes into the seven-segment display controller.
// Optional build macro: OVERFLOW_SAT_EN -- saturate inputs above 99,999,999
// and flag ovf; without it ovf stays 0 and the low eight digits are shown.
//
// state | meaning
// IDLE  | waiting for start, outputs idle
// CONV  | one shift-and-add-3 step per cycle, W cycles
// EMIT  | write digit idx to slot idx, idx = 0..NDIG-1
// DONE  | one-cycle done pulse, then back to IDLE
module bcd_digit_writer
    import calc_pkg::*;
#(
    parameter int W    = 27,
    parameter int NDIG = 8
) (
    input logic               clock,
    input logic               reset,
    bcd_digit_writer_if.slave bus
);

    localparam int BW = 4 * (NDIG + 1);   // one spare digit above the displayed ones
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(NDIG);
    localparam int SW = $clog2(BW);

    bdw_state_t      state, state_next;
    logic [W-1:0]    sh, sh_next;
    logic [BW-1:0]   bcd, bcd_next, bcd_adj;
    logic [BW+W-1:0] shifted;
    logic [CW-1:0]   cnt, cnt_next;
    logic [IW-1:0]   idx, idx_next, idx_inc;
    logic [SW-1:0]   sel;
    logic [3:0]      pos_r, pos_next, dig_r, dig_next;
    logic            busy_r, busy_next, done_r, done_next, ovf_r, ovf_next;
    logic [W-1:0]    cap_value;
    logic            cap_ovf;

    for (genvar g = 0; g < NDIG + 1; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign shifted = {bcd_adj, sh} << 1;
    assign idx_inc = idx + 1'b1;
    assign sel     = SW'({idx_inc, 2'b00});

`ifdef OVERFLOW_SAT_EN
    localparam logic [W-1:0] MAX_W = W'(MAX_DISP);

    // Clamp the captured operand to the largest displayable number.
    always_comb begin
        cap_ovf   = bus.value > MAX_W;
        cap_value = cap_ovf ? MAX_W : bus.value;
    end
`else
    // No clamping: the spare digit absorbs the excess and is never shown.
    always_comb begin
        cap_ovf   = 1'b0;
        cap_value = bus.value;
    end
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next = state;
        sh_next    = sh;
        bcd_next   = bcd;
        cnt_next   = cnt;
        idx_next   = idx;
        pos_next   = POS_IDLE;
        dig_next   = DIG_IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        ovf_next   = ovf_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CONV;
                    sh_next    = cap_value;
                    bcd_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = cap_ovf;
                    busy_next  = 1'b1;
                end
            end
            CONV: begin
                busy_next = 1'b1;
                bcd_next  = shifted[BW+W-1:W];
                sh_next   = shifted[W-1:0];
                cnt_next  = cnt + 1'b1;
                if (cnt == CW'(W - 1)) begin
                    // Last shift: present digit 0 straight from the final result.
                    state_next = EMIT;
                    idx_next   = '0;
                    pos_next   = 4'd0;
                    dig_next   = shifted[W+3:W];
                end
            end
            EMIT: begin
                if (idx == IW'(NDIG - 1)) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    busy_next = 1'b1;
                    idx_next  = idx_inc;
                    pos_next  = 4'(idx_inc);
                    dig_next  = bcd[sel +: 4];
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            sh     <= '0;
            bcd    <= '0;
            cnt    <= '0;
            idx    <= '0;
            pos_r  <= POS_IDLE;
            dig_r  <= DIG_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            state  <= state_next;
            sh     <= sh_next;
            bcd    <= bcd_next;
            cnt    <= cnt_next;
            idx    <= idx_next;
            pos_r  <= pos_next;
            dig_r  <= dig_next;
            busy_r <= busy_next;
            done_r <= done_next;
            ovf_r  <= ovf_next;
        end
    end

    assign bus.pos  = pos_r;
    assign bus.dig  = dig_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_bcd_digit_writer.sv
// Self-checking bench for bcd_digit_writer: directed cases from the plan plus
// random operands, checked against a decimal-arithmetic model and a model of
// the display's digit slots. Honours OVERFLOW_SAT_EN like the design.
module tb_bcd_digit_writer;

    localparam int TW = 27;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    bcd_digit_writer_if #(.W(TW)) bus ();

    bcd_digit_writer #(.W(TW), .NDIG(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int disp [8];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint shown_value(input longint v);
`ifdef OVERFLOW_SAT_EN
        return (v > 64'd99_999_999) ? 64'd99_999_999 : v;
`else
        return v % 100_000_000;
`endif
    endfunction

    function automatic logic exp_ovf(input longint v);
`ifdef OVERFLOW_SAT_EN
        return v > 64'd99_999_999;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_digit(input longint v, input int k);
        longint s = shown_value(v);
        for (int i = 0; i < k; i++) s = s / 10;
        return int'(s % 10);
    endfunction

    // Display-controller model: latch legal writes sampled at the falling edge.
    task automatic display_sample();
        if (bus.pos < 4'd8 && bus.dig < 4'd10) disp[bus.pos] = int'(bus.dig);
    endtask

    // One full conversion. extra_c > 0 pulses start (with extra_v) at that cycle.
    task automatic run_one(input longint v, input int extra_c, input longint extra_v);
        int bad_busy = 0;
        int bad_done = 0;
        int bad_pos  = 0;
        @(negedge clock);
        bus.value = TW'(v);
        bus.start = 1'b1;
        for (int c = 1; c <= TW + 9; c++) begin
            @(negedge clock);
            display_sample();
            if (c <= TW) begin
                if (bus.busy !== 1'b1) bad_busy++;
                if (bus.pos !== 4'hF) bad_pos++;
            end else if (c <= TW + 8) begin
                check_eq("pos", bus.pos, c - TW - 1);
                check_eq("dig", bus.dig, exp_digit(v, c - TW - 1));
                if (bus.busy !== 1'b1) bad_busy++;
            end else begin
                check_eq("done_pulse", bus.done, 1);
                check_eq("busy_end", bus.busy, 0);
                check_eq("pos_done", bus.pos, 4'hF);
                check_eq("ovf", bus.ovf, exp_ovf(v));
            end
            if (c <= TW + 8 && bus.done !== 1'b0) bad_done++;
            bus.start = (c == extra_c);
            if (c == extra_c) bus.value = TW'(extra_v);
            else if (c == 2) bus.value = TW'($urandom);
        end
        @(negedge clock);
        bus.start = 1'b0;
        check_eq("busy_conv_emit", bad_busy, 0);
        check_eq("done_early", bad_done, 0);
        check_eq("pos_conv", bad_pos, 0);
        check_eq("idle_after", {bus.busy, bus.done, bus.pos}, {2'b00, 4'hF});
        for (int k = 0; k < 8; k++) check_eq("display", disp[k], exp_digit(v, k));
    endtask

    initial begin
        int saw_done;
        longint rv;
        for (int k = 0; k < 8; k++) disp[k] = 15;
        bus.start = 1'b0;
        bus.value = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_pos", bus.pos, 4'hF);
        check_eq("rst_dig", bus.dig, 4'hF);
        check_eq("rst_flags", {bus.busy, bus.done, bus.ovf}, 3'b000);
        reset = 1'b0;

        run_one(12_345_678, 0, 0);
        run_one(0, 0, 0);
        run_one(123_456_789, 0, 0);
        run_one(99_999_999, 0, 0);
        run_one(100_000_000, 0, 0);
        run_one(134_217_727, 0, 0);
        // start during CONV is dropped, then honoured once idle again
        run_one(1000, 5, 55);
        run_one(55, 0, 0);
        // start during DONE is ignored
        run_one(7_654_321, TW + 9, 77);
        check_eq("done_start_ignored", bus.busy, 0);

        // reset in the middle of EMIT
        @(negedge clock);
        bus.value = TW'(123_456_789);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        saw_done = 0;
        for (int c = 2; c <= TW + 4; c++) @(negedge clock);
        check_eq("pre_rst_pos", bus.pos, 3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("mid_rst_pos", bus.pos, 4'hF);
        check_eq("mid_rst_dig", bus.dig, 4'hF);
        check_eq("mid_rst_flags", {bus.busy, bus.done, bus.ovf}, 3'b000);
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done++;
        end
        check_eq("no_done_after_rst", saw_done, 0);
        run_one(42, 0, 0);

        for (int i = 0; i < 8; i++) begin
            rv = longint'($urandom_range(134_217_727, 0));
            run_one(rv, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
